// File: rtl/clock_enable_period_monitor.sv
// clock_enable_period_monitor: measures the period of a one-cycle enable strobe,
// locks after LOCK_COUNT identical intervals and flags early, late or missing strobes.
module clock_enable_period_monitor #(
    parameter int W          = 16,
    parameter int LOCK_COUNT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic         locked,
    output logic [W-1:0] period,
    output logic         pow2,
    output logic [4:0]   exponent,
    output logic         err
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [W-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d, cand_q, cand_d, period_q, period_d;
    logic [MW-1:0]  match_q, match_d, match_n;
    logic           locked_q, locked_d, pow2_q, pow2_d, err_q, err_d;
    logic [4:0]     exp_q, exp_d, exp_c;
    logic           pow2_c, hit;

    assign cnt_d = en ? W'(1) : (cnt_q == CMAX ? cnt_q : cnt_q + W'(1));

    always_comb begin
        exp_c = '0;
        for (int i = 0; i < W; i++)
            if (cnt_q[i]) exp_c = 5'(i);
        pow2_c = ((cnt_q & (cnt_q - W'(1))) == '0) && (cnt_q >= W'(2));
    end

    // match counts repeats beyond the candidate itself, so a run of match+1 intervals is complete
    assign match_n = (cnt_q == cand_q) ? match_q + MW'(1) : '0;
    assign hit     = int'(match_n) + 1 == LOCK_COUNT;

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        match_d  = match_q;
        period_d = period_q;
        pow2_d   = pow2_q;
        exp_d    = exp_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: if (en) begin
                state_d = ACQ;
                cand_d  = '0;
                match_d = '0;
            end
            ACQ: if (en) begin
                cand_d  = cnt_q;
                match_d = match_n;
                if (hit) begin
                    state_d  = LOCKED;
                    period_d = cnt_q;
                    pow2_d   = pow2_c;
                    exp_d    = pow2_c ? exp_c : '0;
                end
            end else if (cnt_q == CMAX) begin
                state_d = IDLE;
            end
            // missing strobe is caught as the count passes period, before an interval of period+1 can occur
            LOCKED: if (en ? cnt_q != period_q : cnt_q == period_q) begin
                err_d   = 1'b1;
                state_d = en ? ACQ : IDLE;
                cand_d  = cnt_q;
                match_d = '0;
            end
            default: state_d = IDLE;
        endcase
        locked_d = state_d == LOCKED;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cand_q   <= '0;
            match_q  <= '0;
            period_q <= '0;
            pow2_q   <= 1'b0;
            exp_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            match_q  <= match_d;
            period_q <= period_d;
            pow2_q   <= pow2_d;
            exp_q    <= exp_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign locked   = locked_q;
    assign period   = period_q;
    assign pow2     = pow2_q;
    assign exponent = exp_q;
    assign err      = err_q;
endmodule

// File: tb/tb_clock_enable_period_monitor.sv
// tb_clock_enable_period_monitor: directed strobe sequences against a W=16 and a W=4 instance.
module tb_clock_enable_period_monitor;
    logic        clk = 1'b0, rst, en, en4;
    logic        locked, pow2, err, locked4, pow2_4, err4;
    logic [15:0] period;
    logic [3:0]  period4;
    logic [4:0]  exponent, exp4;
    int          n_chk = 0, n_fail = 0, err_cnt = 0, err4_cnt = 0, e0;

    clock_enable_period_monitor #(.W(16), .LOCK_COUNT(4)) dut (
        .clk(clk), .rst(rst), .en(en), .locked(locked), .period(period),
        .pow2(pow2), .exponent(exponent), .err(err)
    );

    clock_enable_period_monitor #(.W(4), .LOCK_COUNT(4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .locked(locked4), .period(period4),
        .pow2(pow2_4), .exponent(exp4), .err(err4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err) err_cnt++;
        if (err4) err4_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        en = 1'b1;
        tick(1);
        en = 1'b0;
    endtask

    task automatic gap_pulse(input int g);
        tick(g - 1);
        pulse();
    endtask

    task automatic pulse4();
        en4 = 1'b1;
        tick(1);
        en4 = 1'b0;
    endtask

    task automatic gap4(input int g);
        tick(g - 1);
        pulse4();
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        en4 = 1'b0;
        tick(2);
        check("rst_locked", locked, 0);
        check("rst_period", period, 0);
        check("rst_pow2", pow2, 0);
        check("rst_exp", exponent, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        // en held high: interval 1
        en = 1'b1;
        tick(4);
        check("cont_prelock", locked, 0);
        tick(1);
        check("cont_locked", locked, 1);
        check("cont_period", period, 1);
        check("cont_pow2", pow2, 0);
        check("cont_exp", exponent, 0);
        en = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        // period 8
        e0 = err_cnt;
        pulse();
        repeat (3) gap_pulse(8);
        check("p8_prelock", locked, 0);
        gap_pulse(8);
        check("p8_locked", locked, 1);
        check("p8_period", period, 8);
        check("p8_pow2", pow2, 1);
        check("p8_exp", exponent, 3);
        check("p8_noerr", err_cnt - e0, 0);
        gap_pulse(8);
        check("p8_stay", locked, 1);
        // early strobe
        e0 = err_cnt;
        gap_pulse(6);
        check("early_err", err, 1);
        check("early_unlock", locked, 0);
        check("early_period", period, 8);
        tick(1);
        check("early_err_clr", err, 0);
        check("early_one_pulse", err_cnt - e0, 1);
        // relock at 6
        tick(4);
        pulse();
        gap_pulse(6);
        check("p6_prelock", locked, 0);
        check("p6_hold8", period, 8);
        gap_pulse(6);
        check("p6_locked", locked, 1);
        check("p6_period", period, 6);
        check("p6_pow2", pow2, 0);
        check("p6_exp", exponent, 0);
        // async reset between edges
        tick(1);
        #2 rst = 1'b1;
        #1;
        check("arst_locked", locked, 0);
        check("arst_period", period, 0);
        check("arst_pow2", pow2, 0);
        check("arst_exp", exponent, 0);
        rst = 1'b0;
        // period 16, full sequence after reset
        pulse();
        repeat (3) gap_pulse(16);
        check("p16_prelock", locked, 0);
        gap_pulse(16);
        check("p16_locked", locked, 1);
        check("p16_period", period, 16);
        check("p16_pow2", pow2, 1);
        check("p16_exp", exponent, 4);
        // missing strobe
        e0 = err_cnt;
        tick(15);
        check("miss_noerr_yet", err, 0);
        check("miss_still_locked", locked, 1);
        tick(1);
        check("miss_err", err, 1);
        check("miss_unlock", locked, 0);
        tick(1);
        check("miss_err_clr", err, 0);
        check("miss_one_pulse", err_cnt - e0, 1);
        check("miss_period_hold", period, 16);
        pulse();
        repeat (3) gap_pulse(16);
        check("relock16_pre", locked, 0);
        gap_pulse(16);
        check("relock16", locked, 1);
        check("relock16_period", period, 16);
        // W=4 saturation: gap 20 never locks
        pulse4();
        repeat (5) gap4(20);
        check("sat_nolock", locked4, 0);
        check("sat_period", period4, 0);
        check("sat_noerr", err4_cnt, 0);
        // W=4 boundary: gap 15 still fits the counter
        repeat (3) gap4(15);
        check("w4_15_prelock", locked4, 0);
        gap4(15);
        check("w4_15_locked", locked4, 1);
        check("w4_15_period", period4, 15);
        check("w4_15_pow2", pow2_4, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
